// File: rtl/fib_codec_engine_pkg.sv
// ============================================================================
// Module  : fib_codec_engine_pkg
// Purpose : Shared definitions for the Zeckendorf/Fibonacci codec engine:
//           default sizes, request-mode and state encodings, and the
//           Fibonacci constant function used to build the weight ROM.
// Ports   : none (package)
// Rev     : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package fib_codec_engine_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FIB_N_DEF  = 23;
  localparam int LEN_W_DEF  = 5;

  typedef enum logic [1:0] {
    MODE_ENC  = 2'b00,
    MODE_DEC  = 2'b01,
    MODE_LOOP = 2'b10,
    MODE_RSV  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_DEC  = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Weight of Zeckendorf digit i: F[0]=1, F[1]=2, F[2]=3, F[3]=5 ...
  function automatic longint unsigned fib_val(input int i);
    longint unsigned a;
    longint unsigned b;
    longint unsigned t;
    a = 64'd1;
    b = 64'd2;
    for (int k = 0; k < i; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fib_codec_engine_rom.sv
// ============================================================================
// Module  : fib_codec_engine_rom
// Purpose : Combinational Fibonacci weight table, idx -> F[idx], elaborated
//           from fib_val. Indices at or beyond FIB_N return 0.
// Ports   : i_idx  [IDX_W-1:0]  digit index
//           o_fib  [DATA_W:0]   weight of that digit
// Rev     : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module fib_codec_engine_rom
  import fib_codec_engine_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIB_N  = FIB_N_DEF,
  parameter int IDX_W  = 5
) (
  input  logic [IDX_W-1:0] i_idx,
  output logic [DATA_W:0]  o_fib
);

  localparam int FW = DATA_W + 1;

  logic [DATA_W:0] w_tab [FIB_N];

  for (genvar gi = 0; gi < FIB_N; gi++) begin : g_rom
    assign w_tab[gi] = FW'(fib_val(gi));
  end

  always_comb begin
    o_fib = '0;
    if (32'(i_idx) < FIB_N) o_fib = w_tab[i_idx];
  end

endmodule

`default_nettype wire

// File: rtl/fib_codec_engine.sv
// ============================================================================
// Module  : fib_codec_engine
// Purpose : Bit-serial Zeckendorf codec. Encodes a binary word into
//           Zeckendorf digits plus Fibonacci-code length, decodes digits back
//           to binary, or does both back to back (loopback self-check).
//           One digit per clock, one word in flight.
// Ports   : clk, rst (async, active low)
//           in_valid/in_ready, in_mode[1:0], in_data[DATA_W], in_code[FIB_N]
//           out_valid/out_ready, out_data[DATA_W], out_code[FIB_N],
//           out_len[LEN_W], err_invalid, err_ovf, err_mismatch, err_mode, busy
// Rev     : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module fib_codec_engine
  import fib_codec_engine_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIB_N  = FIB_N_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic [FIB_N-1:0]  in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [FIB_N-1:0]  out_code,
  output logic [LEN_W-1:0]  out_len,
  output logic              err_invalid,
  output logic              err_ovf,
  output logic              err_mismatch,
  output logic              err_mode,
  output logic              busy
);

  localparam int IDX_W = (FIB_N > 1) ? $clog2(FIB_N) : 1;
  localparam logic [IDX_W-1:0] c_idx_top = IDX_W'(FIB_N - 1);

  // State and working registers
  state_e            r_state, w_state_nxt;
  mode_e             r_mode, w_mode_nxt;
  logic [DATA_W-1:0] r_data, w_data_nxt;
  logic [FIB_N-1:0]  r_work, w_work_nxt;   // digits being built (ENC) or consumed (DEC)
  logic [DATA_W:0]   r_acc, w_acc_nxt;     // residue in ENC, accumulator in DEC
  logic              r_ovf, w_ovf_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx_nxt;
  logic [LEN_W-1:0]  r_len, w_len_nxt;

  // Output registers
  logic              r_out_valid, w_ov_nxt;
  logic [DATA_W-1:0] r_out_data, w_od_nxt;
  logic [FIB_N-1:0]  r_out_code, w_oc_nxt;
  logic [LEN_W-1:0]  r_out_len, w_ol_nxt;
  logic              r_err_invalid, w_einv_nxt;
  logic              r_err_ovf, w_eovf_nxt;
  logic              r_err_mismatch, w_emis_nxt;
  logic              r_err_mode, w_emode_nxt;

  // Shared datapath
  logic [DATA_W:0]   w_f;
  logic              w_ge;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W+1:0] w_sum;
  logic              w_bit;
  logic [LEN_W-1:0]  w_len_step;

  fib_codec_engine_rom #(
    .DATA_W (DATA_W),
    .FIB_N  (FIB_N),
    .IDX_W  (IDX_W)
  ) u_rom (
    .i_idx (r_idx),
    .o_fib (w_f)
  );

  assign w_ge   = (r_acc >= w_f);
  assign w_diff = r_acc - w_f;
  assign w_sum  = {1'b0, r_acc} + {1'b0, w_f};
  // Digit at the current index: produced by the greedy test when encoding,
  // read from the code when decoding.
  assign w_bit  = (r_state == ST_ENC) ? w_ge : r_work[r_idx];
  // The descent visits the most significant digit first, so the first '1'
  // seen fixes the code length (msb index + terminator).
  assign w_len_step = (w_bit && (r_len == '0)) ? (LEN_W'(r_idx) + LEN_W'(2)) : r_len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_data_nxt  = r_data;
    w_work_nxt  = r_work;
    w_acc_nxt   = r_acc;
    w_ovf_nxt   = r_ovf;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_ov_nxt    = r_out_valid;
    w_od_nxt    = r_out_data;
    w_oc_nxt    = r_out_code;
    w_ol_nxt    = r_out_len;
    w_einv_nxt  = r_err_invalid;
    w_eovf_nxt  = r_err_ovf;
    w_emis_nxt  = r_err_mismatch;
    w_emode_nxt = r_err_mode;

    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_mode_nxt  = mode_e'(in_mode);
          w_data_nxt  = in_data;
          w_idx_nxt   = c_idx_top;
          w_len_nxt   = '0;
          w_ovf_nxt   = 1'b0;
          w_einv_nxt  = 1'b0;
          w_eovf_nxt  = 1'b0;
          w_emis_nxt  = 1'b0;
          w_emode_nxt = 1'b0;
          case (mode_e'(in_mode))
            MODE_ENC, MODE_LOOP: begin
              w_acc_nxt   = {1'b0, in_data};
              w_work_nxt  = '0;
              w_state_nxt = ST_ENC;
            end
            MODE_DEC: begin
              w_acc_nxt   = '0;
              w_work_nxt  = in_code;
              w_state_nxt = ST_DEC;
            end
            default: begin
              // Reserved: echo operands; out_valid follows one edge later.
              w_state_nxt = ST_HOLD;
              w_emode_nxt = 1'b1;
              w_od_nxt    = in_data;
              w_oc_nxt    = in_code;
              w_ol_nxt    = '0;
            end
          endcase
        end
      end

      ST_ENC: begin
        if (w_ge) begin
          w_work_nxt[r_idx] = 1'b1;
          w_acc_nxt         = w_diff;
        end
        w_len_nxt = w_len_step;
        w_idx_nxt = r_idx - IDX_W'(1);
        if (r_idx == '0) begin
          if (r_mode == MODE_LOOP) begin
            // Decode the freshly built code from the top digit again.
            w_state_nxt = ST_DEC;
            w_idx_nxt   = c_idx_top;
            w_acc_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_len_nxt   = '0;
          end else begin
            w_state_nxt = ST_HOLD;
            w_ov_nxt    = 1'b1;
            w_od_nxt    = r_data;
            w_oc_nxt    = w_work_nxt;
            w_ol_nxt    = w_len_step;
          end
        end
      end

      ST_DEC: begin
        if (r_work[r_idx]) begin
          // Any carry into bit DATA_W or beyond means the sum left the word range.
          w_acc_nxt = w_sum[DATA_W:0];
          w_ovf_nxt = r_ovf | w_sum[DATA_W+1] | w_sum[DATA_W];
        end
        w_len_nxt = w_len_step;
        w_idx_nxt = r_idx - IDX_W'(1);
        if (r_idx == '0) begin
          w_state_nxt = ST_HOLD;
          w_ov_nxt    = 1'b1;
          w_od_nxt    = w_acc_nxt[DATA_W-1:0];
          w_oc_nxt    = r_work;
          w_ol_nxt    = w_len_step;
          w_einv_nxt  = |(r_work[FIB_N-1:1] & r_work[FIB_N-2:0]);
          w_eovf_nxt  = w_ovf_nxt;
          w_emis_nxt  = (r_mode == MODE_LOOP) &&
                        (w_ovf_nxt || (w_acc_nxt[DATA_W-1:0] != r_data));
        end
      end

      ST_HOLD: begin
        if (!r_out_valid) begin
          w_ov_nxt = 1'b1;
        end else if (out_ready) begin
          w_ov_nxt    = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode         <= MODE_ENC;
      r_data         <= '0;
      r_work         <= '0;
      r_acc          <= '0;
      r_ovf          <= 1'b0;
      r_idx          <= '0;
      r_len          <= '0;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_code     <= '0;
      r_out_len      <= '0;
      r_err_invalid  <= 1'b0;
      r_err_ovf      <= 1'b0;
      r_err_mismatch <= 1'b0;
      r_err_mode     <= 1'b0;
    end else begin
      r_mode         <= w_mode_nxt;
      r_data         <= w_data_nxt;
      r_work         <= w_work_nxt;
      r_acc          <= w_acc_nxt;
      r_ovf          <= w_ovf_nxt;
      r_idx          <= w_idx_nxt;
      r_len          <= w_len_nxt;
      r_out_valid    <= w_ov_nxt;
      r_out_data     <= w_od_nxt;
      r_out_code     <= w_oc_nxt;
      r_out_len      <= w_ol_nxt;
      r_err_invalid  <= w_einv_nxt;
      r_err_ovf      <= w_eovf_nxt;
      r_err_mismatch <= w_emis_nxt;
      r_err_mode     <= w_emode_nxt;
    end
  end

  assign in_ready     = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_code     = r_out_code;
  assign out_len      = r_out_len;
  assign err_invalid  = r_err_invalid;
  assign err_ovf      = r_err_ovf;
  assign err_mismatch = r_err_mismatch;
  assign err_mode     = r_err_mode;

endmodule

`default_nettype wire

// File: tb/tb_fib_codec_engine.sv
// ============================================================================
// Module  : tb_fib_codec_engine
// Purpose : Self-checking bench for fib_codec_engine: vector table through a
//           scoreboard queue, plus back-pressure and mid-operation reset.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fib_codec_engine;

  localparam int DW = 16;
  localparam int FN = 23;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_mode;
  logic [DW-1:0] in_data;
  logic [FN-1:0] in_code;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [FN-1:0] out_code;
  logic [LW-1:0] out_len;
  logic          err_invalid, err_ovf, err_mismatch, err_mode, busy;

  always #5 clk = ~clk;

  fib_codec_engine #(.DATA_W(DW), .FIB_N(FN), .LEN_W(LW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_mode      (in_mode),
    .in_data      (in_data),
    .in_code      (in_code),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_code     (out_code),
    .out_len      (out_len),
    .err_invalid  (err_invalid),
    .err_ovf      (err_ovf),
    .err_mismatch (err_mismatch),
    .err_mode     (err_mode),
    .busy         (busy)
  );

  typedef struct {
    logic [1:0]    mode;
    logic [DW-1:0] data;
    logic [FN-1:0] code;
    logic [DW-1:0] e_data;
    logic [FN-1:0] e_code;
    logic [LW-1:0] e_len;
    logic [3:0]    e_err;   // {invalid, ovf, mismatch, mode}
    int            e_lat;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] m, input int d, input int c,
                              input int ed, input int ec, input int el,
                              input logic [3:0] ee, input int lat);
    vec_t v;
    v.mode = m; v.data = DW'(d); v.code = FN'(c);
    v.e_data = DW'(ed); v.e_code = FN'(ec); v.e_len = LW'(el);
    v.e_err = ee; v.e_lat = lat;
    return v;
  endfunction

  // Greedy Zeckendorf reference encoder.
  task automatic model_enc(input int val, output logic [FN-1:0] c, output logic [LW-1:0] l);
    int f[FN];
    int r;
    f[0] = 1; f[1] = 2;
    for (int i = 2; i < FN; i++) f[i] = f[i-1] + f[i-2];
    r = val; c = '0; l = '0;
    for (int i = FN-1; i >= 0; i--) begin
      if (r >= f[i]) begin
        c[i] = 1'b1;
        r = r - f[i];
        if (l == '0) l = LW'(i + 2);
      end
    end
  endtask

  function automatic int fib_sum(input logic [FN-1:0] c);
    int a, b, t, s;
    a = 1; b = 2; s = 0;
    for (int i = 0; i < FN; i++) begin
      if (c[i]) s = s + a;
      t = a + b; a = b; b = t;
    end
    return s;
  endfunction

  function automatic logic [3:0] errs();
    return {err_invalid, err_ovf, err_mismatch, err_mode};
  endfunction

  task automatic do_txn(input vec_t v, input int hold_cycles);
    int            cyc;
    vec_t          e;
    logic [63:0]   snap;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_mode = v.mode; in_data = v.data; in_code = v.code;
    @(posedge clk); #1;
    sb.push_back(v);
    // Keep valid high with scrambled operands: must be ignored while busy.
    in_mode = ~v.mode; in_data = ~v.data; in_code = ~v.code;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
    in_valid = 1'b0;
    chk("latency", cyc, v.e_lat);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    chk("out_data", out_data, e.e_data);
    chk("out_code", out_code, e.e_code);
    chk("out_len", out_len, e.e_len);
    chk("errs", errs(), e.e_err);
    chk("in_ready_busy", in_ready, 0);
    if (e.mode == 2'b00 || e.mode == 2'b10) begin
      chk("zeck_adjacent", |(out_code & (out_code >> 1)), 0);
      chk("zeck_value", fib_sum(out_code), e.data);
    end
    snap = {15'd0, out_valid, out_data, out_code, out_len, errs()};
    for (int k = 0; k < hold_cycles; k++) begin
      @(posedge clk); #1;
      chk("hold_stable", {15'd0, out_valid, out_data, out_code, out_len, errs()}, snap);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
    chk("err_persist", errs(), e.e_err);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          v;
    logic [FN-1:0] c;
    logic [LW-1:0] l;
    int            r;

    rst = 1'b0; in_valid = 1'b0; in_mode = '0; in_data = '0; in_code = '0; out_ready = 1'b0;

    // Fixed vectors: mode, data, code, exp data, exp code, exp len, exp err, latency
    tbl.push_back(mk(2'b00, 100,   0,         100,   'h214,    11, 4'b0000, 23));
    tbl.push_back(mk(2'b00, 0,     0,         0,     0,        0,  4'b0000, 23));
    tbl.push_back(mk(2'b00, 65535, 0,         65535, 'h505204, 24, 4'b0000, 23));
    tbl.push_back(mk(2'b00, 1,     0,         1,     'h1,      2,  4'b0000, 23));
    tbl.push_back(mk(2'b00, 4,     0,         4,     'h5,      4,  4'b0000, 23));
    tbl.push_back(mk(2'b01, 0,     'h214,     100,   'h214,    11, 4'b0000, 23));
    tbl.push_back(mk(2'b01, 0,     'h3,       3,     'h3,      3,  4'b1000, 23));
    tbl.push_back(mk(2'b01, 0,     'h540000,  5308,  'h540000, 24, 4'b0100, 23));
    tbl.push_back(mk(2'b01, 0,     'h500000,  64079, 'h500000, 24, 4'b0000, 23));
    tbl.push_back(mk(2'b01, 0,     0,         0,     0,        0,  4'b0000, 23));
    tbl.push_back(mk(2'b01, 0,     'h7FFFFF,  55855, 'h7FFFFF, 24, 4'b1100, 23));
    tbl.push_back(mk(2'b10, 100,   0,         100,   'h214,    11, 4'b0000, 46));
    tbl.push_back(mk(2'b10, 0,     0,         0,     0,        0,  4'b0000, 46));
    tbl.push_back(mk(2'b10, 65535, 0,         65535, 'h505204, 24, 4'b0000, 46));
    tbl.push_back(mk(2'b11, 'h1234,'h5,       'h1234,'h5,      0,  4'b0001, 1));
    for (int i = 0; i < 6; i++) begin
      r = int'($urandom_range(0, 65535));
      model_enc(r, c, l);
      tbl.push_back(mk(2'b00, r, 0, r, int'(c), int'(l), 4'b0000, 23));
    end
    for (int i = 0; i < 16; i++) begin
      r = int'($urandom_range(0, 65535));
      model_enc(r, c, l);
      tbl.push_back(mk(2'b10, r, 0, r, int'(c), int'(l), 4'b0000, 46));
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_code", out_code, 0);
    chk("rst_out_len", out_len, 0);
    chk("rst_errs", errs(), 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // Table: back-pressure on the first encode and on an error decode
    foreach (tbl[i]) do_txn(tbl[i], (i == 0 || i == 6) ? 10 : 0);

    // Reset in the middle of an encode: abort, nothing emitted
    in_valid = 1'b1; in_mode = 2'b00; in_data = 16'd100;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    rst = 1'b0;
    #2;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_outs", {out_data, out_code, out_len, errs()}, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    v = mk(2'b00, 100, 0, 100, 'h214, 11, 4'b0000, 23);
    do_txn(v, 0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
